// File: rtl/dff_write_arbiter_pkg.sv
// Shared types and constants for the write arbiter.
// The lock feature is enabled by defining DFF_WRITE_ARBITER_LOCK_EN.
package dff_write_arbiter_pkg;

    localparam int DEFAULT_DWIDTH = 8;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dff_write_arbiter_rr.sv
// Round-robin grant selection: first asserted request at or after ptr, modulo NREQ.
module rr_arbiter
    import dff_write_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Shared register written by NREQ requesters under round-robin arbitration.
// Optional grant locking is compiled in with DFF_WRITE_ARBITER_LOCK_EN.
module dff_write_arbiter
    import dff_write_arbiter_pkg::*;
#(
    parameter int DWIDTH   = DEFAULT_DWIDTH,
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_clr,
`ifdef DFF_WRITE_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]          req_lock,
`endif
    output logic [NREQ-1:0]          req_ready,
    output logic [DWIDTH-1:0]        q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [DWIDTH-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;

    logic [NREQ-1:0]   lock_req;
    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic [NREQ-1:0]   ready;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     next_idx;
    logic              xfer;

`ifdef DFF_WRITE_ARBITER_LOCK_EN
    assign lock_req = req_lock;
`else
    assign lock_req = '0;
`endif

    rr_arbiter #(
        .NREQ    (NREQ),
        .IW      (IW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Reset gates the grant combinationally so no transfer can be accepted while rst_n is low.
    always_comb begin
        ready = '0;
        if (!rst_n) begin
            ready = '0;
        end else if (state_q == LOCKED) begin
            ready[owner_q] = req_valid[owner_q];
        end else begin
            ready = arb_gnt;
        end
    end

    assign winner   = (state_q == LOCKED) ? owner_q : arb_idx;
    assign xfer     = |(req_valid & ready);
    assign next_idx = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        ptr_d      = ptr_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        gnt_id_d   = gnt_id_q;
        if (xfer) begin
            gnt_id_d = winner;
            if (req_clr[winner]) begin
                q_d       = '0;
                q_valid_d = 1'b0;
            end else begin
                q_d       = req_data[int'(winner)*DWIDTH +: DWIDTH];
                q_valid_d = 1'b1;
            end
            case (state_q)
                UNLOCKED: begin
                    ptr_d = next_idx;
                    if (lock_req[winner] && (LOCK_MAX > 1)) begin
                        state_d    = LOCKED;
                        owner_d    = winner;
                        lock_cnt_d = CW'(1);
                    end
                end
                LOCKED: begin
                    // The beat that brings the count to LOCK_MAX is the last one held.
                    if (!lock_req[winner] || (int'(lock_cnt_q) + 1 >= LOCK_MAX)) begin
                        state_d    = UNLOCKED;
                        lock_cnt_d = '0;
                        ptr_d      = next_idx;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            ptr_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            gnt_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            ptr_q      <= ptr_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            gnt_id_q   <= gnt_id_d;
        end
    end

    assign req_ready = ready;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = xfer | (state_q == LOCKED);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter; lock scenarios run when DFF_WRITE_ARBITER_LOCK_EN is defined.
module tb_dff_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_clr;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  gnt_id;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] qd;
        logic       qv;
    } exp_t;

    exp_t sb[$];

    dff_write_arbiter #(
        .DWIDTH   (8),
        .NREQ     (4),
        .LOCK_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_clr   (req_clr),
`ifdef DFF_WRITE_ARBITER_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .q         (q),
        .q_valid   (q_valid),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // One stimulus cycle: apply inputs, check the combinational grant and busy, queue the expected write.
    task automatic drive(input string nm, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] clr, input logic [3:0] lk, input logic [3:0] er,
                         input logic eb, input logic [7:0] eq, input logic eqv);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_data  = d;
        req_clr   = clr;
        req_lock  = lk;
        #1;
        check({nm, "_ready"}, {28'd0, req_ready}, {28'd0, er});
        check({nm, "_busy"}, {31'd0, busy}, {31'd0, eb});
        if (er != 4'd0) begin
            e.id = onehot_idx(er);
            e.qd = eq;
            e.qv = eqv;
            sb.push_back(e);
        end
    endtask

    // Monitor: a transfer seen in one cycle is compared against the queue after the next edge.
    initial begin
        logic pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && pend) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_unexpected: got transfer id=%0d q=0x%02h, expected none", gnt_id, q);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] xfer id=%0d q=0x%02h q_valid=%0d", gnt_id, q, q_valid);
                    check("sb_gnt_id", {30'd0, gnt_id}, {30'd0, e.id});
                    check("sb_q", {24'd0, q}, {24'd0, e.qd});
                    check("sb_q_valid", {31'd0, q_valid}, {31'd0, e.qv});
                end
            end
            pend = rst_n && (|(req_valid & req_ready));
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'hFFFF_FFFF;
        req_clr   = 4'b0000;
        req_lock  = 4'b0000;
        #12;
        check("rst_q", {24'd0, q}, 32'd0);
        check("rst_q_valid", {31'd0, q_valid}, 32'd0);
        check("rst_gnt_id", {30'd0, gnt_id}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin fairness with all four requesters asserted.
        for (int k = 0; k < 8; k++) begin
            logic [3:0] oh;
            logic [7:0] dv;
            oh = 4'b0001 << (k % 4);
            dv = 8'((k % 4 + 1) * 16);
            drive("rr", 4'b1111, 32'h4030_2010, 4'b0000, 4'b0000, oh, 1'b1, dv, 1'b1);
        end

        // Write then clear.
        drive("wr5a", 4'b0100, 32'h005A_0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 8'h5A, 1'b1);
        drive("clr",  4'b0010, 32'h0000_3300, 4'b0010, 4'b0000, 4'b0010, 1'b1, 8'h00, 1'b0);

        // Idle hold after writing 0xA5.
        drive("wra5", 4'b0001, 32'h0000_00A5, 4'b0000, 4'b0000, 4'b0001, 1'b1, 8'hA5, 1'b1);
        for (int k = 0; k < 10; k++) begin
            drive("idle", 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
            check("idle_q", {24'd0, q}, 32'h0000_00A5);
            check("idle_q_valid", {31'd0, q_valid}, 32'd1);
        end

        // Pointer wrap: search from 1 lands on 3, then wraps to 0.
        drive("wrap3", 4'b1001, 32'h7700_0066, 4'b0000, 4'b0000, 4'b1000, 1'b1, 8'h77, 1'b1);
        drive("wrap0", 4'b1001, 32'h7700_0066, 4'b0000, 4'b0000, 4'b0001, 1'b1, 8'h66, 1'b1);

`ifdef DFF_WRITE_ARBITER_LOCK_EN
        // Requester 1 holds the grant for three beats while requester 0 waits.
        drive("lk1", 4'b0011, 32'h0000_B1B0, 4'b0000, 4'b0010, 4'b0010, 1'b1, 8'hB1, 1'b1);
        drive("lk2", 4'b0011, 32'h0000_C1B0, 4'b0000, 4'b0010, 4'b0010, 1'b1, 8'hC1, 1'b1);
        drive("lkdrop", 4'b0001, 32'h0000_C1B0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b0);
        drive("lk3", 4'b0011, 32'h0000_D1B0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 8'hD1, 1'b1);
        drive("lkafter", 4'b0001, 32'h0000_D1B0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 8'hB0, 1'b1);

        // Requester 3 keeps req_lock high; grant released after its 4th transfer.
        for (int k = 0; k < 4; k++) begin
            drive("force", 4'b1001, 32'hD300_00D0, 4'b0000, 4'b1000, 4'b1000, 1'b1, 8'hD3, 1'b1);
        end
        drive("forcerel", 4'b1001, 32'hD300_00D0, 4'b0000, 4'b1000, 4'b0001, 1'b1, 8'hD0, 1'b1);

        // Enter a lock for requester 2, then reset while locked.
        drive("rl1", 4'b0100, 32'h00E2_0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 8'hE2, 1'b1);
        drive("rl2", 4'b0000, 32'h00E2_0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 8'h00, 1'b0);
`else
        drive("rl1", 4'b0100, 32'h00E2_0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 8'hE2, 1'b1);
        drive("rl2", 4'b0000, 32'h00E2_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
`endif

        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b0101;
        #1;
        check("mid_rst_q", {24'd0, q}, 32'd0);
        check("mid_rst_q_valid", {31'd0, q_valid}, 32'd0);
        check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive("post0", 4'b0101, 32'h00F2_00F0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 8'hF0, 1'b1);
        drive("post2", 4'b0101, 32'h00F2_00F0, 4'b0000, 4'b0000, 4'b0100, 1'b1, 8'hF2, 1'b1);
        drive("tail", 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
